// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: shift-add / restoring divide into HI/LO.
// Define MULDIV_SIGNED_EN to make op 10/11 signed; otherwise every op is unsigned.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int AW = 2*WIDTH + 1;
  localparam int CW = $clog2(WIDTH) + 1;

`ifdef MULDIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [AW-1:0]      acc;
  logic [AW-1:0]      acc_step;
  logic [WIDTH-1:0]   opb;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               is_signed;
  logic               neg_main;
  logic               neg_rem;
  logic               dbz;

  logic               signed_op;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               accept;
  logic               commit;

  logic [WIDTH:0]     sum;
  logic [WIDTH+1:0]   diff;
  logic [AW-1:0]      sh;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  // Signed operands are reduced to magnitudes at latch time
  assign signed_op = SIGNED_EN & op[1];
  assign a_neg     = signed_op & srcA[WIDTH-1];
  assign b_neg     = signed_op & srcB[WIDTH-1];
  assign a_mag     = a_neg ? -srcA : srcA;
  assign b_mag     = b_neg ? -srcB : srcB;

  assign accept = start & ~flush
                & ((state == IDLE) | (state == DONE));
  assign commit = (state_nxt == DONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE,
      DONE: state_nxt = accept ? RUN : IDLE;
      RUN: begin
        if (flush) begin
          state_nxt = IDLE;
        end else if (cnt == CW'(1)) begin
          state_nxt = is_signed ? FIX : DONE;
        end
      end
      FIX: state_nxt = flush ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state == RUN) | (state == FIX);
    done        = (state == DONE);
    div_by_zero = (state == DONE) & dbz;
  end

  // One iteration: shift-add for multiply, restoring subtract for divide
  always_comb begin
    sum  = acc[AW-1:WIDTH] + (acc[0] ? {1'b0, opb} : '0);
    sh   = {acc[AW-2:0], 1'b0};
    diff = {1'b0, sh[AW-1:WIDTH]} - {2'b00, opb};
    if (is_div) begin
      acc_step = diff[WIDTH+1] ? sh
               : {diff[WIDTH:0], sh[WIDTH-1:1], 1'b1};
    end else begin
      acc_step = {1'b0, sum, acc[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod            = acc[2*WIDTH-1:0];
    {res_hi, res_lo} = acc_step[2*WIDTH-1:0];
    if (state == FIX) begin
      if (!is_div) begin
        {res_hi, res_lo} = neg_main ? -prod : prod;
      end else begin
        // A zero divisor keeps the all-ones quotient unnegated
        res_lo = (neg_main & ~dbz) ? -acc[WIDTH-1:0]
                                   : acc[WIDTH-1:0];
        res_hi = neg_rem ? -acc[2*WIDTH-1:WIDTH]
                         : acc[2*WIDTH-1:WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc       <= '0;
      opb       <= '0;
      cnt       <= '0;
      is_div    <= 1'b0;
      is_signed <= 1'b0;
      neg_main  <= 1'b0;
      neg_rem   <= 1'b0;
      dbz       <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      if (accept) begin
        acc       <= {{(WIDTH+1){1'b0}}, a_mag};
        opb       <= b_mag;
        cnt       <= CW'(WIDTH);
        is_div    <= op[0];
        is_signed <= signed_op;
        neg_main  <= a_neg ^ b_neg;
        neg_rem   <= a_neg;
        dbz       <= op[0] & (srcB == '0);
      end else if (state == RUN) begin
        acc <= acc_step;
        cnt <= cnt - CW'(1);
      end
      if (commit) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: random and directed ops vs arithmetic model.
// Honours MULDIV_SIGNED_EN the same way the design does.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] srcA;
  logic [W-1:0] srcB;
  logic         flush;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_by_zero;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  exp_t         sb[$];
  exp_t         got_e;
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;
  logic         prev_done = 1'b0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .op(op),
    .srcA(srcA),
    .srcB(srcB),
    .flush(flush),
    .busy(busy),
    .done(done),
    .hi(hi),
    .lo(lo),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o,
                                 input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t         e;
    logic [63:0]  p;
    bit           sg;
    int           q;
    int           r;
    sg = 1'b0;
`ifdef MULDIV_SIGNED_EN
    sg = o[1];
`endif
    e.dbz = 1'b0;
    if (!o[0]) begin
      if (sg) p = 64'(longint'(int'(a)) * longint'(int'(b)));
      else    p = {32'b0, a} * {32'b0, b};
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == 0) begin
      e.hi  = a;
      e.lo  = '1;
      e.dbz = 1'b1;
    end else if (sg) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.lo = a;
        e.hi = '0;
      end else begin
        q = int'(a) / int'(b);
        r = int'(a) % int'(b);
        e.lo = q;
        e.hi = r;
      end
    end else begin
      e.lo = a / b;
      e.hi = a % b;
    end
    return e;
  endfunction

  function automatic int latency(input logic [1:0] o);
`ifdef MULDIV_SIGNED_EN
    return o[1] ? W + 2 : W + 1;
`else
    return W + 1;
`endif
  endfunction

  // Monitor: pops the scoreboard on every done pulse
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 hi=%0h lo=%0h expected no done",
                 hi, lo);
      end else begin
        got_e = sb.pop_front();
        check("hi", hi, got_e.hi);
        check("lo", lo, got_e.lo);
        check("dbz", div_by_zero, got_e.dbz);
      end
    end else if (prev_done) begin
      check("dbz_clear", div_by_zero, 0);
    end
    prev_done <= done;
  end

  // Issues start now; returns at the negedge of the done cycle
  task automatic run_op(input logic [1:0] o,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input int restart_at);
    exp_t e;
    int   lat_exp;
    int   nb;
    int   lat;
    bit   seen;
    e       = model(o, a, b);
    lat_exp = latency(o);
    nb      = 0;
    lat     = 0;
    seen    = 1'b0;
    sb.push_back(e);
    start = 1'b1;
    op    = o;
    srcA  = a;
    srcB  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 2'($urandom);
    srcA  = $urandom;
    srcB  = $urandom;
    for (int c = 1; c <= lat_exp + 4 && !seen; c++) begin
      @(negedge clk);
      if (busy) nb++;
      if (c == restart_at) begin
        start = 1'b1;
        srcA  = $urandom;
        srcB  = $urandom;
      end
      if (c == restart_at + 1) start = 1'b0;
      if (done) begin
        lat  = c;
        seen = 1'b1;
      end
    end
    start = 1'b0;
    check("latency", lat, lat_exp);
    check("busy_cycles", nb, lat_exp - 1);
    last_hi = e.hi;
    last_lo = e.lo;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]   o;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           k;
    rst   = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op    = '0;
    srcA  = '0;
    srcB  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_dbz", div_by_zero, 0);
    rst = 1'b1;
    @(negedge clk);

    run_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 0);
    run_op(2'b01, 32'd100, 32'd7, 0);
    run_op(2'b01, 32'h1234_5678, 32'h0, 0);

    // Flush in cycle 10, new start in cycle 11
    start = 1'b1;
    op    = 2'b00;
    srcA  = 32'd3;
    srcB  = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check("busy_before_flush", busy, 1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("busy_after_flush", busy, 0);
    check("hi_after_flush", hi, last_hi);
    check("lo_after_flush", lo, last_lo);
    run_op(2'b00, $urandom, $urandom, 0);

    run_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 0);
    run_op(2'b01, 32'd5000, 32'd13, 5);

    // Restart ignored in cycle 5, reset in cycle 20
    @(posedge clk);
    #1;
    start = 1'b1;
    op    = 2'b01;
    srcA  = $urandom;
    srcB  = $urandom_range(1, 1000);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    srcA  = $urandom;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst2_busy", busy, 0);
    check("rst2_done", done, 0);
    check("rst2_hi", hi, 0);
    check("rst2_lo", lo, 0);
    check("rst2_dbz", div_by_zero, 0);
    last_hi = '0;
    last_lo = '0;
    repeat (40) @(negedge clk);
    check("hi_idle_after_rst", hi, 0);

    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      k = $urandom_range(0, 7);
      if (k == 0) b = '0;
      if (k == 1) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      if (k == 2) b = $urandom_range(1, 15);
      if (k == 3) a = $urandom_range(0, 100);
      if (k == 4) a = -($urandom_range(1, 1000));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      run_op(o, a, b, 0);
    end

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
